// File: rtl/act_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
//   Shared definitions for the post-saturation activation stages.
//   ACT_W        : activation width (int16)
//   LEAKY_MUL    : leaky ReLU slope numerator   (slope = 13/128)
//   LEAKY_SHIFT  : leaky ReLU slope denominator as a right shift
//   leaky_int16(): YOLOv3-tiny leaky ReLU on one int16 activation
// ---------------------------------------------------------------------------
package act_pkg;

    localparam int ACT_W       = 16;
    localparam int LEAKY_MUL   = 13;
    localparam int LEAKY_SHIFT = 7;
    localparam int PROD_W      = 21;

    typedef logic signed [ACT_W-1:0] act_t;

    // Negative inputs are scaled by 13/128. The arithmetic shift floors
    // toward minus infinity, so the most negative result is -3328 and the
    // value always fits back into int16 without saturation.
    function automatic act_t leaky_int16(input act_t x);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(x) * PROD_W'(LEAKY_MUL);
        if (x[ACT_W-1]) begin
            return act_t'(prod >>> LEAKY_SHIFT);
        end
        return x;
    endfunction

endpackage

// File: rtl/fifo2_reg.sv
// ---------------------------------------------------------------------------
// fifo2_reg
//   Generic two-entry register FIFO. The head entry always lives in slot0,
//   so pop_data is a plain register output and never changes unless a pop
//   occurs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full)
//   push_data   : W-bit entry to write
//   pop         : discard the head entry (ignored when empty)
//   pop_data    : head entry
//   count       : number of stored entries (0..2)
//   full, empty : status flags derived from count
// ---------------------------------------------------------------------------
module fifo2_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full     = (cnt == 2'd2);
    assign empty    = (cnt == 2'd0);
    assign count    = cnt;
    assign pop_data = slot0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= push_data;
                    end else begin
                        slot1 <= push_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry stored: the incoming
                    // word replaces the departing head, count unchanged.
                    slot0 <= push_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/leaky_relu_pack_int16.sv
// ---------------------------------------------------------------------------
// leaky_relu_pack_int16
//   Applies the leaky ReLU (slope 13/128) to an int16 element stream and
//   packs PACK activations per output word, with valid/ready handshaking
//   and a two-entry output buffer.
//   PACK      : activations per output word (2..8)
//   LEAKY_EN  : 1 = leaky ReLU, 0 = identity
//   clk, rst_n: clock, asynchronous active-low reset
//   in_data   : signed activation            in_valid : element valid
//   in_last   : element closes a row/tile    in_ready : element accepted
//   out_data  : packed word, lane 0 = first element at bits [15:0]
//   out_keep  : lane-valid mask              out_last : word closes row/tile
//   out_valid : word valid                   out_ready: downstream accepts
// ---------------------------------------------------------------------------
module leaky_relu_pack_int16
    import act_pkg::*;
#(
    parameter int PACK     = 4,
    parameter int LEAKY_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ACT_W-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [ACT_W*PACK-1:0]   out_data,
    output logic [PACK-1:0]         out_keep,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int                CNT_W     = $clog2(PACK);
    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(PACK - 1);
    localparam int                FIFO_W    = ACT_W * PACK + PACK + 1;

    act_t                  y;
    logic [CNT_W-1:0]      lane_cnt;
    logic [ACT_W-1:0]      lane_reg [PACK-1];
    logic                  run_q;
    logic                  accept;
    logic                  closing;
    logic                  push;
    logic [ACT_W*PACK-1:0] word_data;
    logic [PACK-1:0]       word_keep;
    logic [FIFO_W-1:0]     head;
    logic [1:0]            fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign y = (LEAKY_EN != 0) ? leaky_int16(in_data) : in_data;

    // run_q keeps in_ready low while reset is asserted and releases it on
    // the first clock edge afterwards.
    assign in_ready = run_q && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign closing  = (lane_cnt == LAST_LANE) || in_last;
    assign push     = accept && closing;

    // Word assembly: stored lanes below lane_cnt, the current element at
    // lane_cnt, zeros above. The top lane can only ever hold y.
    for (genvar g = 0; g < PACK - 1; g++) begin : g_lane
        assign word_data[ACT_W*g +: ACT_W] =
            (CNT_W'(g) < lane_cnt)  ? lane_reg[g] :
            (CNT_W'(g) == lane_cnt) ? y           : '0;
    end
    assign word_data[ACT_W*(PACK-1) +: ACT_W] = (lane_cnt == LAST_LANE) ? y : '0;

    assign word_keep[0] = 1'b1;
    for (genvar g = 1; g < PACK; g++) begin : g_keep
        assign word_keep[g] = (CNT_W'(g) <= lane_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            for (int unsigned i = 0; i < PACK - 1; i++) begin
                lane_reg[i] <= '0;
            end
        end else if (accept) begin
            if (closing) begin
                lane_cnt <= '0;
            end else begin
                lane_cnt <= lane_cnt + CNT_W'(1);
                for (int unsigned i = 0; i < PACK - 1; i++) begin
                    if (CNT_W'(i) == lane_cnt) begin
                        lane_reg[i] <= y;
                    end
                end
            end
        end
    end

    fifo2_reg #(
        .W (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({in_last, word_keep, word_data}),
        .pop       (out_valid && out_ready),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = (fifo_count != 2'd0);

    always_comb begin
        out_data = '0;
        out_keep = '0;
        out_last = 1'b0;
        if (!fifo_empty) begin
            {out_last, out_keep, out_data} = head;
        end
    end

endmodule

// File: tb/tb_leaky_relu_pack_int16.sv
module tb_leaky_relu_pack_int16;

    localparam int PACK = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b0;

    logic               in_ready, in_ready_i;
    logic [63:0]        out_data, out_data_i;
    logic [3:0]         out_keep, out_keep_i;
    logic               out_last, out_last_i;
    logic               out_valid, out_valid_i;

    always #5 clk = ~clk;

    leaky_relu_pack_int16 #(.PACK(PACK), .LEAKY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    leaky_relu_pack_int16 #(.PACK(PACK), .LEAKY_EN(0)) dut_id (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_i), .out_data(out_data_i),
        .out_keep(out_keep_i), .out_last(out_last_i), .out_valid(out_valid_i),
        .out_ready(out_ready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference leaky ReLU via integer floor division.
    function automatic logic [15:0] mleaky(input logic signed [15:0] x);
        int v;
        v = x;
        if (v < 0) v = -(((-v) * 13 + 127) / 128);
        return 16'(v);
    endfunction

    typedef struct {
        logic [63:0] dl;
        logic [63:0] di;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t       q[$];
    logic [15:0] pl[4];
    logic [15:0] pi[4];
    int          pcnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_pop = 1'b0;
    logic [63:0] prev_data = '0;
    bit          acc_f;

    // One clock cycle against the reference model, using currently driven inputs.
    task automatic cyc();
        word_t w;
        bit    exp_rdy;
        @(negedge clk);
        exp_rdy = (q.size() < 2);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("in_ready_id", 64'(in_ready_i), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (prev_valid && !prev_pop) chk("stable", out_data, prev_data);
        acc_f = in_valid && exp_rdy;
        prev_valid = out_valid;
        prev_pop   = out_valid && out_ready;
        prev_data  = out_data;
        if (q.size() != 0) begin
            chk("data", out_data, q[0].dl);
            chk("data_id", out_data_i, q[0].di);
            chk("keep", 64'(out_keep), 64'(q[0].keep));
            chk("last", 64'(out_last), 64'(q[0].last));
            if (out_ready) void'(q.pop_front());
        end
        if (acc_f) begin
            pl[pcnt] = mleaky(in_data);
            pi[pcnt] = in_data;
            if (pcnt == 3 || in_last) begin
                w.dl = '0;
                w.di = '0;
                for (int k = 0; k <= pcnt; k++) begin
                    w.dl[16*k +: 16] = pl[k];
                    w.di[16*k +: 16] = pi[k];
                end
                w.keep = 4'((1 << (pcnt + 1)) - 1);
                w.last = in_last;
                q.push_back(w);
                pcnt = 0;
            end else begin
                pcnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          n;
        logic        lst;
        shortint     x[4];
        shortint     el[4];
        logic [3:0]  keep;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [63:0] e_l, e_i;
        int nacc, idx, cycles;

        vt[0].n = 4; vt[0].lst = 1'b0; vt[0].x = '{100, -100, -1, -32768};
        vt[0].el = '{100, -11, -1, -3328}; vt[0].keep = 4'hF;
        vt[1].n = 2; vt[1].lst = 1'b1; vt[1].x = '{-5, 7, 0, 0};
        vt[1].el = '{-1, 7, 0, 0};         vt[1].keep = 4'h3;
        vt[2].n = 1; vt[2].lst = 1'b1; vt[2].x = '{-128, 0, 0, 0};
        vt[2].el = '{-13, 0, 0, 0};        vt[2].keep = 4'h1;
        vt[3].n = 4; vt[3].lst = 1'b1; vt[3].x = '{32767, -129, 0, -10};
        vt[3].el = '{32767, -14, 0, -2};   vt[3].keep = 4'hF;
        vt[4].n = 3; vt[4].lst = 1'b1; vt[4].x = '{1, -2, -3, 0};
        vt[4].el = '{1, -1, -1, 0};        vt[4].keep = 4'h7;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_out_keep", 64'(out_keep), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 64'(in_ready), 64'(1));

        // Table-driven single words with out_ready=1
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vt[v].n; k++) begin
                in_valid = 1'b1;
                in_data  = vt[v].x[k];
                in_last  = vt[v].lst && (k == vt[v].n - 1);
                @(negedge clk);
                chk("vec_in_ready", 64'(in_ready), 64'(1));
                chk("vec_valid_pre", 64'(out_valid), 64'(0));
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            e_l = '0;
            e_i = '0;
            for (int k = 0; k < 4; k++) begin
                e_l[16*k +: 16] = 16'(vt[v].el[k]);
                e_i[16*k +: 16] = 16'(vt[v].x[k]);
            end
            chk("vec_latency", 64'(out_valid), 64'(1));
            chk("vec_data", out_data, e_l);
            chk("vec_data_id", out_data_i, e_i);
            chk("vec_keep", 64'(out_keep), 64'(vt[v].keep));
            chk("vec_keep_id", 64'(out_keep_i), 64'(vt[v].keep));
            chk("vec_last", 64'(out_last), 64'(vt[v].lst));
            @(posedge clk);
            #1;
            chk("vec_popped", 64'(out_valid), 64'(0));
        end

        // Stall: 12 elements with out_ready=0, then release
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx < 12);
            in_data  = 16'(idx + 1);
            in_last  = 1'b0;
            cyc();
            if (acc_f) idx++;
        end
        chk("stall_accepted", 64'(idx), 64'(8));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        cycles = 0;
        while ((idx < 12 || q.size() != 0 || out_valid) && cycles < 60) begin
            in_valid = (idx < 12);
            in_data  = 16'(idx + 1);
            cyc();
            if (acc_f) idx++;
            cycles++;
        end
        chk("stall_resumed", 64'(idx), 64'(12));
        chk("stall_drained", 64'(out_valid), 64'(0));

        // in_last on every element: one 1-lane word per cycle
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = 16'(-3 * c);
            cyc();
            if (acc_f) nacc++;
        end
        chk("lastall_accepts", 64'(nacc), 64'(8));
        in_valid = 1'b0;
        in_last  = 1'b0;
        cyc();
        cyc();

        // Reset mid-word with one word buffered
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(-(c + 10));
            cyc();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        chk("midrst_out_data", out_data, 64'(0));
        q.delete();
        pcnt = 0;
        prev_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rel_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("midrst_rel_high", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(20 + c);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();

        // Random valid/ready/last against the reference model
        nacc = 0;
        cycles = 0;
        while (nacc < 3000 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 6) == 0);
            out_ready = ($urandom_range(0, 4) > 1);
            case ($urandom_range(0, 7))
                0: in_data = 16'h8000;
                1: in_data = 16'h7FFF;
                2: in_data = 16'hFFFF;
                default: in_data = 16'($urandom);
            endcase
            cyc();
            if (acc_f) nacc++;
            cycles++;
        end
        chk("rand_progress", 64'(nacc), 64'(3000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("rand_drained", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
